// File: rtl/reg_mem_fifo_ctrl_if.sv
// Stream and memory-port bundle for reg_mem_fifo_ctrl.
// Handshake rule: a word moves on a rising clk edge exactly when its valid
// and ready are both 1 in that cycle. Valid never waits on ready. The data
// for that word must be stable while valid is high and the word has not yet
// been accepted. The master modport is the controller's view. The slave
// modport is the view of the surrounding source, sink and reg_mem.
interface reg_mem_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_BITS  = 3
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_BITS-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  in_data, in_valid, out_ready, mem_rdata,
    output in_ready, out_data, out_valid, mem_addr, mem_wdata, mem_wen
  );

  modport slave (
    output in_data, in_valid, out_ready, mem_rdata,
    input  in_ready, out_data, out_valid, mem_addr, mem_wdata, mem_wen
  );
endinterface

// File: rtl/reg_mem_fifo_ctrl.sv
// FIFO controller in front of a single-port reg_mem.
// Input words are written into reg_mem and fetched back in order into a
// registered output stage. The one address port alternates between writes
// and fetches when both are wanted.
// Optional feature macro: REG_MEM_FIFO_BYPASS_EN. When it is defined, a word
// that arrives while reg_mem is empty and the output stage can take it is
// loaded directly into the output stage.
module reg_mem_fifo_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_BITS  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  reg_mem_fifo_ctrl_if.master   bus,
  output logic [ADDR_BITS:0]    count,
  output logic                  full,
  output logic                  empty
);
  localparam int                 DEPTH        = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_C      = (ADDR_BITS + 1)'(DEPTH);
  localparam logic               GRANT_READ   = 1'b0;
  localparam logic               GRANT_WRITE  = 1'b1;

  logic [ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]    count_q, count_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  last_grant_q, last_grant_d;

  logic out_free;
  logic fetch_need;
  logic in_ready;
  logic byp_fire;
  logic wr_fire;
  logic rd_fire;

  // Arbitration: a write loses to a pending fetch only when the last access was a write
  always_comb begin
    out_free   = !out_valid_q || bus.out_ready;
    fetch_need = (count_q != '0) && out_free;
    in_ready   = rst_n && (count_q != DEPTH_C) && !(fetch_need && (last_grant_q == GRANT_WRITE));
`ifdef REG_MEM_FIFO_BYPASS_EN
    byp_fire   = (count_q == '0) && out_free && bus.in_valid && in_ready;
`else
    byp_fire   = 1'b0;
`endif
    wr_fire    = bus.in_valid && in_ready && !byp_fire;
    rd_fire    = fetch_need && !wr_fire;
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_wen   = wr_fire;
  assign bus.mem_addr  = wr_fire ? wr_ptr_q : rd_ptr_q;
  assign bus.mem_wdata = bus.in_data;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign count         = count_q;
  assign full          = (count_q == DEPTH_C);
  assign empty         = (count_q == '0) && !out_valid_q;

  // Next state: at most one memory access per cycle, so count moves by at most one
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    if (wr_fire) begin
      wr_ptr_d     = wr_ptr_q + 1'b1;
      count_d      = count_q + 1'b1;
      last_grant_d = GRANT_WRITE;
    end
    if (rd_fire) begin
      out_data_d   = bus.mem_rdata;
      out_valid_d  = 1'b1;
      rd_ptr_d     = rd_ptr_q + 1'b1;
      count_d      = count_q - 1'b1;
      last_grant_d = GRANT_READ;
    end else if (byp_fire) begin
      out_data_d   = bus.in_data;
      out_valid_d  = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // State registers with immediate reset; reg_mem contents are left untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= GRANT_READ;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end
endmodule
